// File: rtl/pit_prog_arbiter.sv
// Purpose: shares the PIT 8-bit I/O slave port between the CPU bus and an internal
//          master that loads {control word, LSB, MSB} into one counter atomically.
// Latency: CPU pass-through is combinational in IDLE; internal grant at G, writes G+1..G+3, prog_ack G+4.
// Backpressure: cpu_waitrequest stalls the CPU in the grant cycle and for the whole internal sequence.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cpu_address/read/write/writedata CPU I/O access (offset 0-3 = 40h-43h, 5 = 61h)
//   cpu_readdata, cpu_waitrequest    read data (straight from PIT), stall
//   prog_req/channel/mode/divisor    internal programming request (level, held until ack)
//   prog_ack, prog_err, prog_busy    completion pulse, illegal-channel flag, sequence active
//   pit_address/read/write/writedata PIT slave port drive
//   pit_readdata                     PIT read data (registered inside the PIT)
module pit_prog_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_writedata,
   output logic [7:0]  cpu_readdata,
   output logic        cpu_waitrequest,
   input  logic        prog_req,
   input  logic [1:0]  prog_channel,
   input  logic [2:0]  prog_mode,
   input  logic [15:0] prog_divisor,
   output logic        prog_ack,
   output logic        prog_err,
   output logic        prog_busy,
   output logic [2:0]  pit_address,
   output logic        pit_read,
   output logic        pit_write,
   output logic [7:0]  pit_writedata,
   input  logic [7:0]  pit_readdata
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CTRL,
      S_LSB,
      S_MSB,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      cap_channel;
   logic [2:0]      cap_mode;
   logic [15:0]     cap_divisor;
   logic [SW-1:0]   starve_cnt;
   logic [2:0][1:0] rw;
   logic [2:0]      msb_pending;

   logic cpu_access;
   logic chan_pending;
   logic grant;
   logic cpu_wr_eff;

   assign cpu_access   = cpu_read | cpu_write;
   assign cpu_readdata = pit_readdata;
   assign prog_busy    = (state != S_IDLE);

   // Channel 3 has no shadow; it is never blocked and completes with prog_err.
   always_comb begin
      chan_pending = 1'b0;
      case (prog_channel)
         2'd0:    chan_pending = msb_pending[0];
         2'd1:    chan_pending = msb_pending[1];
         2'd2:    chan_pending = msb_pending[2];
         default: chan_pending = 1'b0;
      endcase
   end

   // A half-finished CPU two-byte load blocks the grant even when starved.
   assign grant = rst_n && (state == S_IDLE) && prog_req && !chan_pending &&
                  (!cpu_access || (starve_cnt == STARVE_MAX));

   // A CPU write counts for the shadow only if it actually reaches the PIT.
   assign cpu_wr_eff = rst_n && (state == S_IDLE) && !grant && cpu_write;

   // Next state and outputs.
   always_comb begin
      state_nxt       = state;
      cpu_waitrequest = 1'b1;
      prog_ack        = 1'b0;
      prog_err        = 1'b0;
      pit_address     = 3'd0;
      pit_read        = 1'b0;
      pit_write       = 1'b0;
      pit_writedata   = 8'd0;
      case (state)
         S_IDLE: begin
            cpu_waitrequest = grant;
            // Outputs sit at zero while reset is held, whatever the CPU drives.
            if (rst_n) begin
               pit_address   = cpu_address;
               pit_writedata = cpu_writedata;
               pit_read      = cpu_read & ~grant;
               pit_write     = cpu_write & ~grant;
            end
            if (grant) begin
               state_nxt = (prog_channel == 2'd3) ? S_DONE : S_CTRL;
            end
         end
         S_CTRL: begin
            // Binary count, RW = LSB then MSB.
            pit_write     = 1'b1;
            pit_address   = 3'd3;
            pit_writedata = {cap_channel, 2'b11, cap_mode, 1'b0};
            state_nxt     = S_LSB;
         end
         S_LSB: begin
            pit_write     = 1'b1;
            pit_address   = {1'b0, cap_channel};
            pit_writedata = cap_divisor[7:0];
            state_nxt     = S_MSB;
         end
         S_MSB: begin
            pit_write     = 1'b1;
            pit_address   = {1'b0, cap_channel};
            pit_writedata = cap_divisor[15:8];
            state_nxt     = S_DONE;
         end
         S_DONE: begin
            prog_ack  = 1'b1;
            prog_err  = (cap_channel == 2'd3);
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cap_channel <= 2'd0;
         cap_mode    <= 3'd0;
         cap_divisor <= 16'd0;
         starve_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            cap_channel <= prog_channel;
            cap_mode    <= prog_mode;
            cap_divisor <= prog_divisor;
         end
         // Counts cycles a pending request loses to the CPU; saturates so the
         // forced grant stays armed until it is actually taken.
         if (state == S_IDLE) begin
            if (!prog_req || grant) begin
               starve_cnt <= '0;
            end else if (cpu_access && (starve_cnt != STARVE_MAX)) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
      end
   end

   // Shadow of the 8254 RW field and LSB/MSB flip-flop per counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw          <= '0;
         msb_pending <= '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (cpu_wr_eff && (cpu_address == 3'd3) &&
                (cpu_writedata[7:6] == 2'(c)) && (cpu_writedata[5:4] != 2'd0)) begin
               rw[c]          <= cpu_writedata[5:4];
               msb_pending[c] <= 1'b0;
            end else if (cpu_wr_eff && (cpu_address == 3'(c)) && (rw[c] == 2'd3)) begin
               msb_pending[c] <= ~msb_pending[c];
            end
            // The internal sequence leaves the counter in LSB/MSB mode, fully loaded.
            if ((state == S_MSB) && (cap_channel == 2'(c))) begin
               rw[c]          <= 2'd3;
               msb_pending[c] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pit_prog_arbiter.sv
module tb_pit_prog_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [7:0]  cpu_writedata;
   logic [7:0]  cpu_readdata;
   logic        cpu_waitrequest;
   logic        prog_req;
   logic [1:0]  prog_channel;
   logic [2:0]  prog_mode;
   logic [15:0] prog_divisor;
   logic        prog_ack;
   logic        prog_err;
   logic        prog_busy;
   logic [2:0]  pit_address;
   logic        pit_read;
   logic        pit_write;
   logic [7:0]  pit_writedata;
   logic [7:0]  pit_readdata = 8'h00;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks   = 0;
   int  failures = 0;

   always #5 clk = ~clk;

   pit_prog_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cpu_address     (cpu_address),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_writedata   (cpu_writedata),
      .cpu_readdata    (cpu_readdata),
      .cpu_waitrequest (cpu_waitrequest),
      .prog_req        (prog_req),
      .prog_channel    (prog_channel),
      .prog_mode       (prog_mode),
      .prog_divisor    (prog_divisor),
      .prog_ack        (prog_ack),
      .prog_err        (prog_err),
      .prog_busy       (prog_busy),
      .pit_address     (pit_address),
      .pit_read        (pit_read),
      .pit_write       (pit_write),
      .pit_writedata   (pit_writedata),
      .pit_readdata    (pit_readdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic req(input logic [1:0] ch, input logic [2:0] mode, input logic [15:0] div);
      prog_req     = 1'b1;
      prog_channel = ch;
      prog_mode    = mode;
      prog_divisor = div;
   endtask

   // PIT model: registered read data, one cycle after the strobe.
   always @(posedge clk) begin
      if (pit_read) pit_readdata <= 8'hA0 | {5'd0, pit_address};
   end

   // Scoreboard: every PIT write must match the next expected write in order.
   always @(negedge clk) begin
      if (pit_write === 1'b1) begin
         chk("pit_wr_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pit_wr_addr", pit_address, mon_e.a);
            chk("pit_wr_data", pit_writedata, mon_e.d);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      cpu_address = 3'd0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = 8'd0;
      prog_req = 1'b0; prog_channel = 2'd0; prog_mode = 3'd0; prog_divisor = 16'd0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {cpu_waitrequest, prog_ack, prog_err, prog_busy, pit_write,
                            pit_read, pit_address, pit_writedata}, 0);
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {cpu_waitrequest, prog_busy, prog_ack}, 0);

      // Idle CPU, single internal request: ch0 mode3 0x1234
      tick(); req(2'd0, 3'd3, 16'h1234);
      push(3'd3, 8'h36); push(3'd0, 8'h34); push(3'd0, 8'h12);
      @(negedge clk);
      chk("t1_grant_wait", cpu_waitrequest, 1);
      chk("t1_grant_busy", prog_busy, 0);
      tick(); prog_divisor = 16'hFFFF; prog_mode = 3'd0; prog_channel = 2'd2;
      @(negedge clk);
      chk("t1_ctrl_busy", prog_busy, 1);
      chk("t1_ctrl_wr", pit_write, 1);
      tick(); @(negedge clk); chk("t1_lsb_wr", pit_write, 1);
      tick(); @(negedge clk); chk("t1_msb_wr", pit_write, 1);
      tick(); @(negedge clk);
      chk("t1_ack", prog_ack, 1);
      chk("t1_err", prog_err, 0);
      chk("t1_ack_wait", cpu_waitrequest, 1);
      tick(); prog_req = 1'b0;
      @(negedge clk);
      chk("t1_after_ack", {prog_ack, prog_busy, cpu_waitrequest}, 0);

      // Illegal channel
      tick(); req(2'd3, 3'd1, 16'h5555);
      @(negedge clk); chk("t2_grant_wait", cpu_waitrequest, 1);
      tick(); @(negedge clk);
      chk("t2_ack", prog_ack, 1);
      chk("t2_err", prog_err, 1);
      chk("t2_no_write", pit_write, 0);
      tick(); prog_req = 1'b0;
      @(negedge clk); chk("t2_idle", {prog_ack, prog_busy}, 0);

      // Starvation: CPU writes port 61h every cycle
      tick(); req(2'd1, 3'd2, 16'hABCD);
      cpu_write = 1'b1; cpu_address = 3'd5; cpu_writedata = 8'h01; push(3'd5, 8'h01);
      @(negedge clk); chk("t3_cpu_wins_1", cpu_waitrequest, 0);
      for (int i = 2; i <= 4; i++) begin
         tick(); cpu_writedata = 8'(i); push(3'd5, 8'(i));
         @(negedge clk); chk("t3_cpu_wins", cpu_waitrequest, 0);
      end
      tick(); cpu_writedata = 8'h05;
      push(3'd3, 8'h74); push(3'd1, 8'hCD); push(3'd1, 8'hAB); push(3'd5, 8'h05);
      @(negedge clk);
      chk("t3_forced_grant", cpu_waitrequest, 1);
      chk("t3_grant_no_wr", pit_write, 0);
      for (int k = 0; k < 4; k++) begin
         tick(); @(negedge clk); chk("t3_stall", cpu_waitrequest, 1);
      end
      chk("t3_ack", prog_ack, 1);
      tick(); prog_req = 1'b0;
      @(negedge clk); chk("t3_cpu_resumes", cpu_waitrequest, 0);
      tick(); cpu_write = 1'b0;

      // Split-load protection on channel 2
      tick(); cpu_write = 1'b1; cpu_address = 3'd3; cpu_writedata = 8'hB6; push(3'd3, 8'hB6);
      @(negedge clk); chk("t4_ctrl_pass", cpu_waitrequest, 0);
      tick(); cpu_address = 3'd2; cpu_writedata = 8'h00; push(3'd2, 8'h00);
      tick(); cpu_write = 1'b0; req(2'd2, 3'd0, 16'h0102);
      @(negedge clk); chk("t4_blocked_wait", cpu_waitrequest, 0);
      tick(); @(negedge clk); chk("t4_blocked_busy", prog_busy, 0);
      tick(); @(negedge clk); chk("t4_blocked_busy2", prog_busy, 0);
      tick(); cpu_write = 1'b1; cpu_writedata = 8'h10; push(3'd2, 8'h10);
      @(negedge clk); chk("t4_msb_passes", cpu_waitrequest, 0);
      tick(); cpu_write = 1'b0;
      push(3'd3, 8'hB0); push(3'd2, 8'h02); push(3'd2, 8'h01);
      @(negedge clk); chk("t4_grant", cpu_waitrequest, 1);
      repeat (4) tick();
      @(negedge clk); chk("t4_ack", prog_ack, 1);
      tick(); prog_req = 1'b0;

      // CPU read stalled during a sequence
      tick(); req(2'd0, 3'd2, 16'h0005);
      push(3'd3, 8'h34); push(3'd0, 8'h05); push(3'd0, 8'h00);
      tick();
      tick(); cpu_read = 1'b1; cpu_address = 3'd0;
      @(negedge clk);
      chk("t5_read_stalled", cpu_waitrequest, 1);
      chk("t5_no_pit_read", pit_read, 0);
      tick(); @(negedge clk); chk("t5_no_pit_read2", pit_read, 0);
      tick(); @(negedge clk);
      chk("t5_ack", prog_ack, 1);
      chk("t5_no_pit_read3", pit_read, 0);
      tick(); prog_req = 1'b0;
      @(negedge clk);
      chk("t5_read_passes", pit_read, 1);
      chk("t5_read_wait", cpu_waitrequest, 0);
      chk("t5_read_addr", pit_address, 0);
      tick(); cpu_read = 1'b0;
      @(negedge clk); chk("t5_readdata", cpu_readdata, 8'hA0);

      // Reset mid-sequence
      tick(); req(2'd1, 3'd0, 16'h0303); push(3'd3, 8'h70);
      tick();
      tick(); rst_n = 1'b0;
      @(negedge clk);
      chk("t6_reset_outputs", {cpu_waitrequest, prog_ack, prog_err, prog_busy, pit_write,
                               pit_read, pit_address, pit_writedata}, 0);
      tick(); prog_req = 1'b0;
      @(negedge clk); chk("t6_no_ack", prog_ack, 0);
      tick(); rst_n = 1'b1;
      @(negedge clk); chk("t6_idle", {prog_ack, prog_busy}, 0);
      tick(); cpu_write = 1'b1; cpu_address = 3'd0; cpu_writedata = 8'h55; push(3'd0, 8'h55);
      @(negedge clk); chk("t6_cpu_pass", cpu_waitrequest, 0);
      tick(); cpu_write = 1'b0;
      @(negedge clk);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
